cpu_state_uart_tx: RTL



---
 rtl/cpu_state_uart_tx_if.sv | 21 ++
 rtl/cpu_state_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_state_uart_tx_if.sv
// Signal bundle between the CPU debug port and the state-dump UART transmitter.
// master = transmitter side, slave = CPU/board side.
interface cpu_state_uart_tx_if;
    logic        start;
    logic [31:0] status_in;
    logic [3:0]  reg_addr;
    logic [31:0] reg_data;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        input  start, status_in, reg_data,
        output reg_addr, tx, busy, done
    );

    modport slave (
        output start, status_in, reg_data,
        input  reg_addr, tx, busy, done
    );
endinterface

// File: rtl/cpu_state_uart_tx.sv
// Purpose: dumps status word + r0..r15 as one UART 8N1 frame (A5, status, regs); optional XOR byte via CPU_STATE_TX_CHECKSUM_EN.
// Latency: start sampled in IDLE, start bit on the next cycle; frame = bytes*10*CLKS_PER_BIT cycles, done one cycle after.
// Backpressure: none; start is ignored while busy, a held start relaunches in the done cycle.
module cpu_state_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_state_uart_tx_if.master   bus
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_STAT,
        S_REGS,
        S_CSUM
    } top_t;

    typedef enum logic [1:0] {
        B_START,
        B_DATA,
        B_STOP
    } bit_t;

    top_t        r_top;
    bit_t        r_bit_st;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_byte;
    logic [31:0] r_word;
    logic        r_last;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_reg_addr;
`ifdef CPU_STATE_TX_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic w_baud_end;
    logic w_word_end;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_word_end = (r_byte_idx == 2'd3);

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.reg_addr = r_reg_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_top      <= S_IDLE;
            r_bit_st   <= B_START;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_byte     <= '0;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reg_addr <= '0;
`ifdef CPU_STATE_TX_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_top == S_IDLE) begin
                r_tx     <= 1'b1;
                r_baud   <= '0;
                r_bit_st <= B_START;
                if (bus.start) begin
                    // r_word doubles as the status shadow while the header goes out
                    r_top      <= S_HDR;
                    r_busy     <= 1'b1;
                    r_tx       <= 1'b0;
                    r_byte     <= 8'hA5;
                    r_word     <= bus.status_in;
                    r_byte_idx <= '0;
                    r_bit_cnt  <= '0;
                    r_last     <= 1'b0;
`ifdef CPU_STATE_TX_CHECKSUM_EN
                    r_csum     <= '0;
`endif
                end
            end else if (!w_baud_end) begin
                r_baud <= r_baud + 1'b1;
            end else begin
                r_baud <= '0;
                case (r_bit_st)
                    B_START: begin
                        r_bit_st  <= B_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_byte[0];
                    end
                    B_DATA: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_st <= B_STOP;
                            r_tx     <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_byte    <= r_byte >> 1;
                            r_tx      <= r_byte[1];
                        end
                    end
                    default: begin
                        // stop bit complete: pick the next byte, or close the frame
                        r_bit_st <= B_START;
                        r_tx     <= 1'b0;
                        case (r_top)
                            S_HDR: begin
                                r_top      <= S_STAT;
                                r_byte     <= r_word[7:0];
                                r_byte_idx <= '0;
`ifdef CPU_STATE_TX_CHECKSUM_EN
                                r_csum     <= r_csum ^ r_word[7:0];
`endif
                            end
                            S_STAT, S_REGS: begin
                                if (!w_word_end) begin
                                    r_byte_idx <= r_byte_idx + 2'd1;
                                    r_byte     <= r_word[15:8];
                                    r_word     <= r_word >> 8;
`ifdef CPU_STATE_TX_CHECKSUM_EN
                                    r_csum     <= r_csum ^ r_word[15:8];
`endif
                                end else if ((r_top == S_STAT) || !r_last) begin
                                    r_top      <= S_REGS;
                                    r_word     <= bus.reg_data;
                                    r_byte     <= bus.reg_data[7:0];
                                    r_byte_idx <= '0;
                                    r_last     <= (r_reg_addr == 4'd15);
                                    if (r_reg_addr != 4'd15) begin
                                        r_reg_addr <= r_reg_addr + 4'd1;
                                    end
`ifdef CPU_STATE_TX_CHECKSUM_EN
                                    r_csum     <= r_csum ^ bus.reg_data[7:0];
`endif
                                end else begin
`ifdef CPU_STATE_TX_CHECKSUM_EN
                                    r_top  <= S_CSUM;
                                    r_byte <= r_csum;
`else
                                    r_top      <= S_IDLE;
                                    r_busy     <= 1'b0;
                                    r_done     <= 1'b1;
                                    r_tx       <= 1'b1;
                                    r_reg_addr <= '0;
`endif
                                end
                            end
                            default: begin
                                r_top      <= S_IDLE;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_tx       <= 1'b1;
                                r_reg_addr <= '0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule
